// File: rtl/lcd_write_arbiter.sv
// Arbitrates NREQ requesters onto a single hex LCD writer and tracks its busy handshake.
// Define LCD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module lcd_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*DW-1:0]      i_req_data,
    output logic [NREQ-1:0]         o_ack,
    output logic                    o_lcd_start,
    output logic [DW-1:0]           o_lcd_data,
    input  logic                    i_lcd_busy,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_arb_busy,
    output logic                    o_timeout_err,
    input  logic                    i_clear_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   w_grant_next;
    logic [DW-1:0]   r_lcd_data;
    logic [DW-1:0]   w_data_next;
    logic            r_lcd_start;
    logic            r_arb_busy;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            w_err_set;
    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [DW-1:0]   w_slice [NREQ];
    logic [NREQ-1:0] w_ack_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_slice[gi]   = i_req_data[gi*DW +: DW];
            assign w_ack_vec[gi] = (r_grant_id == IW'(gi));
        end
    endgenerate

`ifdef LCD_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_found  = 1'b1;
                w_winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] r_rr_ptr;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // First set request at or after r_rr_ptr, wrapping past NREQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rr_ptr <= '0;
        end else if (r_state == S_DONE) begin
            r_rr_ptr <= (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_next = r_grant_id;
        w_data_next  = r_lcd_data;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_lcd_busy && w_found) begin
                    w_grant_next = w_winner;
                    w_data_next  = w_slice[w_winner];
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i_lcd_busy) begin
                    w_state_next = S_WAIT_LO;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        w_err_set    = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!i_lcd_busy) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a plain register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_grant_id  <= '0;
            r_lcd_data  <= '0;
            r_lcd_start <= 1'b0;
            r_arb_busy  <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_grant_id  <= w_grant_next;
            r_lcd_data  <= w_data_next;
            r_lcd_start <= (w_state_next == S_START);
            r_arb_busy  <= (w_state_next != S_IDLE);
            r_ack       <= (w_state_next == S_DONE) ? w_ack_vec : '0;
            r_err       <= w_err_set | (r_err & ~i_clear_err);
        end
    end

    assign o_ack         = r_ack;
    assign o_lcd_start   = r_lcd_start;
    assign o_lcd_data    = r_lcd_data;
    assign o_grant_id    = r_grant_id;
    assign o_arb_busy    = r_arb_busy;
    assign o_timeout_err = r_err;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter; honours LCD_ARB_FIXED_PRIO_EN for the arbitration order.
module tb_lcd_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  ack;
    logic             lcd_start;
    logic [DW-1:0]    lcd_data;
    logic             lcd_busy;
    logic [1:0]       grant_id;
    logic             arb_busy;
    logic             timeout_err;
    logic             clear_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    lcd_write_arbiter #(.NREQ(NREQ), .DW(DW), .ACK_TIMEOUT(8)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_req         (req),
        .i_req_data    (req_data),
        .o_ack         (ack),
        .o_lcd_start   (lcd_start),
        .o_lcd_data    (lcd_data),
        .i_lcd_busy    (lcd_busy),
        .o_grant_id    (grant_id),
        .o_arb_busy    (arb_busy),
        .o_timeout_err (timeout_err),
        .i_clear_err   (clear_err)
    );

    always @(negedge clk) if (lcd_start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int idx, input logic [DW-1:0] v);
        req_data[idx*DW +: DW] = v;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (lcd_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(output bit ok, output logic [NREQ-1:0] seen);
        ok   = 1'b0;
        seen = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ack !== '0) begin
                ok   = 1'b1;
                seen = ack;
                break;
            end
        end
    endtask

    // Writer: busy rises one cycle after the start pulse and stays high for len cycles.
    task automatic writer(input int len);
        tick();
        lcd_busy = 1'b1;
        repeat (len) tick();
        lcd_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_data = '0; lcd_busy = 1'b1; clear_err = 1'b0;
        #3;
        checks++;
        if ({ack, lcd_start, lcd_data, grant_id, arb_busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b start=%b data=%h gid=%0d busy=%b err=%b required all 0",
                     ack, lcd_start, lcd_data, grant_id, arb_busy, timeout_err);
        end
        tick(); tick();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_powerup();
        bit ok;
        logic [NREQ-1:0] seen;
        int s0;
        set_slice(0, 16'h1234);
        req = 4'b0001;
        s0 = start_cnt;
        repeat (100) tick();
        checks++;
        if (start_cnt != s0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL powerup_no_start: got starts=%0d arb_busy=%b required 0 0", start_cnt - s0, arb_busy);
        end
        lcd_busy = 1'b0;
        wait_start(ok);
        checks++;
        if (!ok || lcd_data !== 16'h1234 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL powerup_grant: got ok=%b data=%h gid=%0d required 1 1234 0", ok, lcd_data, grant_id);
        end
        writer(10);
        wait_ack(ok, seen);
        checks++;
        if (!ok || seen !== 4'b0001) begin
            errors++;
            $display("FAIL powerup_ack: got %b required 0001", seen);
        end
        tick();
        req = '0;
        checks++;
        if (ack !== '0 || arb_busy !== 1'b0 || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL powerup_after_ack: got ack=%b arb_busy=%b starts=%0d required 0000 0 1",
                     ack, arb_busy, start_cnt - s0);
        end
        $display("powerup: grant 0 data %h ack %b", lcd_data, seen);
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [NREQ-1:0] seen;
        logic [DW-1:0] vals [4];
        int exp_id [4];
        vals[0] = 16'hA000; vals[1] = 16'hA111; vals[2] = 16'hA222; vals[3] = 16'hA333;
`ifdef LCD_ARB_FIXED_PRIO_EN
        exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 0; exp_id[3] = 0;
`else
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 3; exp_id[3] = 0;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_slice(i, vals[i]);
        req = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            wait_start(ok);
            checks++;
            if (!ok || grant_id !== 2'(exp_id[n]) || lcd_data !== vals[exp_id[n]]) begin
                errors++;
                $display("FAIL rr_grant%0d: got ok=%b gid=%0d data=%h required gid=%0d data=%h",
                         n, ok, grant_id, lcd_data, exp_id[n], vals[exp_id[n]]);
            end
            writer(20);
            wait_ack(ok, seen);
            checks++;
            if (!ok || seen !== (4'b0001 << exp_id[n])) begin
                errors++;
                $display("FAIL rr_ack%0d: got %b required %b", n, seen, 4'b0001 << exp_id[n]);
            end
            tick();
            checks++;
            if (ack !== '0 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap%0d: got ack=%b arb_busy=%b required 0000 0", n, ack, arb_busy);
            end
            $display("round_robin: grant %0d -> id %0d ack %b", n, exp_id[n], seen);
        end
        req = '0;
        tick();
    endtask

    task automatic test_latency();
        bit ok;
        logic [NREQ-1:0] seen;
        lcd_busy = 1'b0;
        set_slice(2, 16'hBEEF);
        tick(); tick();
        req = 4'b0100;
        checks++;
        if (lcd_start !== 1'b0) begin
            errors++;
            $display("FAIL latency_before: got start=%b required 0", lcd_start);
        end
        tick();
        checks++;
        if (lcd_start !== 1'b1 || lcd_data !== 16'hBEEF || grant_id !== 2'd2 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_start: got start=%b data=%h gid=%0d busy=%b required 1 beef 2 1",
                     lcd_start, lcd_data, grant_id, arb_busy);
        end
        tick();
        checks++;
        if (lcd_start !== 1'b0) begin
            errors++;
            $display("FAIL latency_one_cycle: got start=%b required 0", lcd_start);
        end
        lcd_busy = 1'b1;
        repeat (3) tick();
        lcd_busy = 1'b0;
        wait_ack(ok, seen);
        checks++;
        if (!ok || seen !== 4'b0100) begin
            errors++;
            $display("FAIL latency_ack: got %b required 0100", seen);
        end
        tick();
        req = '0;
        $display("latency: start one cycle after req, data %h", lcd_data);
    endtask

    task automatic test_timeout();
        bit ok;
        bit early;
        logic [NREQ-1:0] seen;
        set_slice(0, 16'h5555);
        req = 4'b0001;
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_start: got no start required start");
        end
        early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || ack !== '0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_early: got err/ack during 8 wait cycles required none");
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_set: got err=%b ack=%b required 1 0001", timeout_err, ack);
        end
        tick();
        req = '0;
        set_slice(1, 16'h6666);
        req = 4'b0010;
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 2'd1 || lcd_data !== 16'h6666) begin
            errors++;
            $display("FAIL timeout_next_grant: got ok=%b gid=%0d data=%h required 1 1 6666", ok, grant_id, lcd_data);
        end
        writer(5);
        wait_ack(ok, seen);
        checks++;
        if (!ok || seen !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_next_ack: got %b required 0010", seen);
        end
        tick();
        req = '0;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b required 1", timeout_err);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b required 0", timeout_err);
        end
        $display("timeout: err set after 8 cycles, next request served, cleared");
    endtask

    task automatic test_reset_midop();
        bit ok;
        logic [NREQ-1:0] seen;
        set_slice(0, 16'h1111);
        req = 4'b0001;
        wait_start(ok);
        tick();
        lcd_busy = 1'b1;
        tick(); tick();
        checks++;
        if (!ok || arb_busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midop_inflight: got ok=%b busy=%b gid=%0d required 1 1 0", ok, arb_busy, grant_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, lcd_start, lcd_data, grant_id, arb_busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL midop_async_reset: got ack=%b data=%h gid=%0d busy=%b required all 0",
                     ack, lcd_data, grant_id, arb_busy);
        end
        lcd_busy = 1'b0;
        req = 4'b0100;
        set_slice(2, 16'h2222);
        tick(); tick();
        rst_n = 1'b1;
        wait_start(ok);
        checks++;
        if (!ok || grant_id !== 2'd2 || lcd_data !== 16'h2222) begin
            errors++;
            $display("FAIL midop_fresh_grant: got ok=%b gid=%0d data=%h required 1 2 2222", ok, grant_id, lcd_data);
        end
        writer(4);
        wait_ack(ok, seen);
        checks++;
        if (!ok || seen !== 4'b0100) begin
            errors++;
            $display("FAIL midop_ack: got %b required 0100", seen);
        end
        tick();
        req = '0;
        $display("reset_midop: fresh grant 2, ack %b", seen);
    endtask

    task automatic test_data_stability();
        bit ok;
        logic [NREQ-1:0] seen;
        set_slice(3, 16'hCAFE);
        req = 4'b1000;
        wait_start(ok);
        checks++;
        if (!ok || lcd_data !== 16'hCAFE || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL stable_grant: got ok=%b data=%h gid=%0d required 1 cafe 3", ok, lcd_data, grant_id);
        end
        tick();
        lcd_busy = 1'b1;
        tick();
        set_slice(3, 16'hDEAD);
        tick();
        checks++;
        if (lcd_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL stable_wait_lo: got %h required cafe", lcd_data);
        end
        lcd_busy = 1'b0;
        wait_ack(ok, seen);
        checks++;
        if (!ok || seen !== 4'b1000) begin
            errors++;
            $display("FAIL stable_ack: got %b required 1000", seen);
        end
        tick();
        req = '0;
        tick();
        checks++;
        if (lcd_data !== 16'hCAFE || grant_id !== 2'd3 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL stable_idle_hold: got data=%h gid=%0d busy=%b required cafe 3 0", lcd_data, grant_id, arb_busy);
        end
        req = 4'b1000;
        wait_start(ok);
        checks++;
        if (!ok || lcd_data !== 16'hDEAD) begin
            errors++;
            $display("FAIL stable_next_grant: got ok=%b data=%h required 1 dead", ok, lcd_data);
        end
        writer(2);
        wait_ack(ok, seen);
        tick();
        req = '0;
        $display("data_stability: held cafe through write, next grant %h", lcd_data);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_round_robin();
        test_latency();
        test_timeout();
        test_reset_midop();
        test_data_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single 16-bit hex LCD writer between up to NREQ requesters, e.g. CPU store port, debug UART, switch monitor.
- Arbitrates pending requests and issues a one-cycle start with the winner's value.
- Tracks the writer's busy handshake through completion, then acknowledges the winner.
- Sits between the requesters and the LCD writer's start/data_in/busy pins. Detects a writer that never accepts a start.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, data width per requester, matches the writer's data_in.
- ACK_TIMEOUT, 8, cycles to wait for lcd_busy to rise after a start before declaring a timeout (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester level request; held until its ack.
- req_data  in  NREQ*DW  packed values; slice i = req_data[i*DW +: DW]; sampled at grant.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- lcd_start  out  1  one-cycle start pulse to the LCD writer.
- lcd_data  out  DW  value presented to the writer; held stable from grant until the next grant.
- lcd_busy  in  1  writer busy (high during writer init and during a write).
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- arb_busy  out  1  high from grant until the ack cycle, inclusive.
- timeout_err  out  1  sticky; set on an accept timeout.
- clear_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset values (reset=0, asynchronous): all outputs 0, state S_IDLE, rr_ptr=0, timeout counter 0.
- All outputs are registered.
- S_IDLE:
  - If lcd_busy=0 and req≠0: pick the winner (round-robin, first set bit at or after rr_ptr, wrapping).
  - On the winner, latch lcd_data and grant_id, set arb_busy=1, go to S_START.
  - If lcd_busy=1 (e.g. writer init after power-up), grant nothing and wait.
- S_START:
  - lcd_start=1 for exactly this one cycle. Clear the counter, go to S_WAIT_HI.
  - Latency: req seen in S_IDLE at edge N gives lcd_start high during cycle N+1.
- S_WAIT_HI:
  - lcd_busy=1: go to S_WAIT_LO.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, set timeout_err and go to S_DONE; the ack is still issued.
- S_WAIT_LO: stay while lcd_busy=1. On lcd_busy=0, go to S_DONE.
- S_DONE:
  - ack[grant_id]=1 for one cycle, arb_busy=1.
  - rr_ptr = grant_id+1, wrapping to 0 past NREQ-1.
  - Go to S_IDLE; arb_busy=0 from the next cycle.
- Requesters must deassert or re-present req on the edge where they see ack. A req still high in S_IDLE is treated as a new request.
- A req dropped before its grant is simply not served. After grant, req is ignored until S_DONE; the latched data is used.
- req_data of non-granted requesters is never sampled.
- timeout_err:
  - clear_err=1 clears it.
  - If clear_err and a new timeout occur in the same cycle, set wins.
- Reset asserted mid-transfer: the arbiter returns to S_IDLE immediately and no ack is issued for the in-flight request. lcd_start is deasserted asynchronously.
- grant_id and lcd_data retain their values in S_IDLE.

Optional Feature:
- Macro LCD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, the lowest index among set req bits always wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Power-up wait: hold lcd_busy=1 for 100 cycles with req=4'b0001 and req_data slice0=16'h1234 → no lcd_start while busy. After busy falls, exactly one lcd_start, lcd_data=16'h1234, grant_id=0. Then busy high 10 cycles, then low → ack=4'b0001 one cycle.
- Round-robin: req=4'b1011 held continuously and re-presented after each ack, writer model (busy one cycle after start, 20 cycles long) → grant order 0,1,3,0; each ack one cycle; arb_busy low for ≥1 cycle between grants. With LCD_ARB_FIXED_PRIO_EN defined → order 0,0,0,0.
- Latency: lcd_busy=0, req[2] rises at edge N → lcd_start high during cycle N+1 only, lcd_data = slice2.
- Timeout: lcd_busy stuck 0 after start → timeout_err=1 after 8 waiting cycles, ack pulses, next request still served. clear_err=1 → timeout_err=0 next cycle.
- Reset mid-op: reset=0 during S_WAIT_LO → all outputs 0 asynchronously. After release with req=4'b0100 → fresh grant to 2, no stale ack to the prior requester.
- Data stability: change req_data slice of the granted requester during S_WAIT_LO → lcd_data unchanged until the next grant.
